// File: rtl/comp_search_if.sv
// Probe/flag bus between a search engine and a comp magnitude comparator.
// master drives probe and reads isbig/iseq/issmall; slave is the comparator.
interface comp_search_if #(
  parameter int W = 4
);

  logic [W-1:0] probe;
  logic         isbig;
  logic         iseq;
  logic         issmall;

  modport master (
    output probe,
    input  isbig,
    input  iseq,
    input  issmall
  );

  modport slave (
    input  probe,
    output isbig,
    output iseq,
    output issmall
  );

endinterface

// File: rtl/comp_search.sv
// Binary-search engine that locates the comparator's unknown a input.
// Ports: clk, rst_n (sync, active-low), start, cmp (probe/flag bus),
// busy, done (1-cycle pulse), found, err, result, steps (held until start).
module comp_search #(
  parameter int W       = 4,
  parameter int CMP_LAT = 1,
  parameter int SW      = $clog2(W + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  comp_search_if.master        cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 err,
  output logic [W-1:0]         result,
  output logic [SW-1:0]        steps
);

  localparam int CW =
    (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  localparam logic [CW-1:0] CLAST =
    CW'(CMP_LAT - 1);

  localparam logic [W-1:0] MAXV = '1;

  generate
    if (CMP_LAT < 1) begin : g_lat_chk
      $error("CMP_LAT must be at least 1");
    end
    if (W < 1) begin : g_w_chk
      $error("W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DONE
  } state_t;

  state_t          st_q;
  state_t          st_d;

  logic [W-1:0]    probe_q;
  logic [W-1:0]    probe_d;
  logic [W-1:0]    lo_q;
  logic [W-1:0]    lo_d;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    hi_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic            busy_q;
  logic            busy_d;
  logic            done_q;
  logic            done_d;
  logic            found_q;
  logic            found_d;
  logic            err_q;
  logic            err_d;
  logic [W-1:0]    result_q;
  logic [W-1:0]    result_d;
  logic [SW-1:0]   steps_q;
  logic [SW-1:0]   steps_d;

  logic            onehot;
  logic            sample;
  logic [W:0]      sum;

  // True for exactly one flag: xor catches odd counts,
  // the and-term rejects all three.
  assign onehot =
    (cmp.isbig ^ cmp.iseq ^ cmp.issmall) &
    ~(cmp.isbig & cmp.iseq & cmp.issmall);

  assign sample = (cnt_q == CLAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      probe_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      steps_q  <= '0;
    end else begin
      st_q     <= st_d;
      probe_q  <= probe_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
      steps_q  <= steps_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    probe_d  = probe_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    steps_d  = steps_q;
    sum      = '0;

    unique case (st_q)
      IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = MAXV;
          probe_d  = MAXV >> 1;
          steps_d  = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
          cnt_d    = '0;
          st_d     = PROBE;
        end
      end

      PROBE: begin
        if (!sample) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          steps_d = steps_q + 1'b1;
          if (!onehot) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b1;
            st_d   = DONE;
          end else begin
            unique case (1'b1)
              cmp.iseq: begin
                found_d  = 1'b1;
                result_d = probe_q;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                st_d     = DONE;
              end
              cmp.isbig: begin
                if (probe_q == hi_q) begin
                  err_d  = 1'b1;
                  busy_d = 1'b0;
                  done_d = 1'b1;
                  st_d   = DONE;
                end else begin
                  lo_d = probe_q + 1'b1;
                end
              end
              cmp.issmall: begin
                // probe==lo also covers probe==0,
                // so the decrement never wraps.
                if (probe_q == lo_q) begin
                  err_d  = 1'b1;
                  busy_d = 1'b0;
                  done_d = 1'b1;
                  st_d   = DONE;
                end else begin
                  hi_d = probe_q - 1'b1;
                end
              end
              default: begin
                st_d = st_q;
              end
            endcase
            // Midpoint in W+1 bits so lo+hi cannot overflow.
            if (st_d == PROBE) begin
              sum     = {1'b0, lo_d} + {1'b0, hi_d};
              probe_d = sum[W:1];
            end
          end
        end
      end

      DONE: begin
        st_d = IDLE;
      end

      default: begin
        st_d = IDLE;
      end
    endcase
  end

  assign cmp.probe = probe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign err       = err_q;
  assign result    = result_q;
  assign steps     = steps_q;

endmodule

// File: tb/tb_comp_search.sv
// Directed bench for comp_search: real comparators at CMP_LAT 1 and 3,
// forced-flag cases, mid-search reset and held start.
module tb_comp_search;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1;
  logic       start2;
  logic       busy1, done1, found1, err1;
  logic       busy2, done2, found2, err2;
  logic [3:0] result1, result2;
  logic [2:0] steps1, steps2;

  logic [3:0] aval;
  logic       ovr;
  logic [2:0] fl;
  logic [3:0] d1, d2;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] seq1;
  int dk1, dk2, dw1, dw2;
  int nd;

  comp_search_if #(.W(4)) if1 ();
  comp_search_if #(.W(4)) if2 ();

  comp_search #(.W(4), .CMP_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .cmp(if1.master),
    .busy(busy1), .done(done1), .found(found1),
    .err(err1), .result(result1), .steps(steps1)
  );

  comp_search #(.W(4), .CMP_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .cmp(if2.master),
    .busy(busy2), .done(done2), .found(found2),
    .err(err2), .result(result2), .steps(steps2)
  );

  always_comb begin
    if (ovr) begin
      {if1.isbig, if1.iseq, if1.issmall} = fl;
    end else begin
      if1.isbig   = aval > if1.probe;
      if1.iseq    = aval == if1.probe;
      if1.issmall = aval < if1.probe;
    end
  end

  // Comparator whose flags trail the probe by two registers,
  // so they are valid exactly 3 edges after a probe change.
  always_ff @(posedge clk) begin
    d1 <= if2.probe;
    d2 <= d1;
  end

  assign if2.isbig   = aval > d2;
  assign if2.iseq    = aval == d2;
  assign if2.issmall = aval < d2;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int exp_steps(input int a);
    int lo, hi, p, n;
    lo = 0; hi = 15; n = 0;
    while (n < 10) begin
      p = (lo + hi) / 2;
      n++;
      if (p == a) return n;
      if (a > p) lo = p + 1;
      else hi = p - 1;
    end
    return -1;
  endfunction

  task automatic go(input logic [3:0] a);
    aval = a;
    seq1 = 0; dk1 = 0; dk2 = 0; dw1 = 0; dw2 = 0;
    @(negedge clk);
    start1 = 1'b1;
    start2 = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      if (busy1) seq1 = (seq1 << 4) | 32'(if1.probe);
      if (done1) begin
        if (dk1 == 0) dk1 = k;
        dw1++;
      end
      if (done2) begin
        if (dk2 == 0) dk2 = k;
        dw2++;
      end
      if (dk1 != 0 && dk2 != 0 &&
          k > dk1 + 1 && k > dk2 + 1) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    aval = 4'd0; ovr = 1'b0; fl = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_probe",  32'(if1.probe), 0);
    chk("rst_busy",   32'(busy1), 0);
    chk("rst_done",   32'(done1), 0);
    chk("rst_found",  32'(found1), 0);
    chk("rst_err",    32'(err1), 0);
    chk("rst_result", 32'(result1), 0);
    chk("rst_steps",  32'(steps1), 0);

    go(4'd5);
    chk("a5_seq",    seq1, 32'h735);
    chk("a5_found",  32'(found1), 1);
    chk("a5_result", 32'(result1), 5);
    chk("a5_steps",  32'(steps1), 3);
    chk("a5_err",    32'(err1), 0);
    chk("a5_dk",     32'(dk1), 4);
    chk("a5_dw",     32'(dw1), 1);

    go(4'd0);
    chk("a0_seq",    seq1, 32'h7310);
    chk("a0_found",  32'(found1), 1);
    chk("a0_result", 32'(result1), 0);
    chk("a0_steps",  32'(steps1), 4);

    go(4'd15);
    chk("a15_seq",    seq1, 32'h7bdef);
    chk("a15_found",  32'(found1), 1);
    chk("a15_result", 32'(result1), 15);
    chk("a15_steps",  32'(steps1), 5);

    for (int a = 0; a < 16; a++) begin
      go(4'(a));
      chk($sformatf("sw1_found_%0d", a), 32'(found1), 1);
      chk($sformatf("sw1_res_%0d", a), 32'(result1), 32'(a));
      chk($sformatf("sw1_steps_%0d", a),
          32'(steps1), 32'(exp_steps(a)));
      chk($sformatf("sw1_le5_%0d", a), 32'(steps1 <= 5), 1);
      chk($sformatf("sw1_dk_%0d", a),
          32'(dk1), 32'(exp_steps(a) + 1));
      chk($sformatf("sw1_dw_%0d", a), 32'(dw1), 1);
      chk($sformatf("sw3_found_%0d", a), 32'(found2), 1);
      chk($sformatf("sw3_res_%0d", a), 32'(result2), 32'(a));
      chk($sformatf("sw3_steps_%0d", a),
          32'(steps2), 32'(exp_steps(a)));
      chk($sformatf("sw3_dk_%0d", a),
          32'(dk2), 32'(exp_steps(a) * 3 + 1));
      chk($sformatf("sw3_dw_%0d", a), 32'(dw2), 1);
    end

    ovr = 1'b1;
    fl = 3'b110;
    go(4'd9);
    chk("be_seq",    seq1, 32'h7);
    chk("be_err",    32'(err1), 1);
    chk("be_found",  32'(found1), 0);
    chk("be_result", 32'(result1), 0);
    chk("be_steps",  32'(steps1), 1);

    fl = 3'b000;
    go(4'd9);
    chk("z_err",   32'(err1), 1);
    chk("z_found", 32'(found1), 0);
    chk("z_steps", 32'(steps1), 1);

    fl = 3'b100;
    go(4'd9);
    chk("ab_seq",   seq1, 32'h7bdef);
    chk("ab_err",   32'(err1), 1);
    chk("ab_found", 32'(found1), 0);
    chk("ab_steps", 32'(steps1), 5);
    chk("ab_dk",    32'(dk1), 6);
    ovr = 1'b0;

    aval = 4'd10;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("mr_p1", 32'(if1.probe), 7);
    @(negedge clk);
    chk("mr_p2", 32'(if1.probe), 11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_probe",  32'(if1.probe), 0);
    chk("mr_busy",   32'(busy1), 0);
    chk("mr_done",   32'(done1), 0);
    chk("mr_found",  32'(found1), 0);
    chk("mr_err",    32'(err1), 0);
    chk("mr_result", 32'(result1), 0);
    chk("mr_steps",  32'(steps1), 0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done1 || busy1) nd++;
    end
    chk("mr_quiet", 32'(nd), 0);
    go(4'd10);
    chk("mr2_found",  32'(found1), 1);
    chk("mr2_result", 32'(result1), 10);
    chk("mr2_steps",  32'(steps1), 4);

    aval = 4'd5;
    seq1 = 0; nd = 0;
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy1) seq1 = (seq1 << 4) | 32'(if1.probe);
      if (done1) begin
        nd++;
        start1 = 1'b0;
        break;
      end
    end
    chk("hs_seq",  seq1, 32'h735);
    chk("hs_done", 32'(nd), 1);
    @(negedge clk);
    chk("hs_idle1", 32'(busy1), 0);
    @(negedge clk);
    chk("hs_idle2", 32'(busy1), 0);
    chk("hs_nodone", 32'(done1), 0);
    go(4'd12);
    chk("hs2_found",  32'(found1), 1);
    chk("hs2_result", 32'(result1), 12);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
